// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param: parametrised full-duplex UART transceiver.
//   TX: FIFO_DEPTH-entry FIFO with a valid/ready write port, feeding a shifter
//       that sends start, DATA_BITS data bits (LSB first), optional parity and
//       STOP_BITS stop bits, each bit lasting CLKS_PER_BIT clocks.
//   RX: 2-flop synchroniser, start-bit glitch rejection, mid-bit sampling,
//       parity and framing error flags delivered with a one-cycle rx_valid_o.
// Ports:
//   clk_i           system clock, rising edge
//   rst_i           synchronous active-high reset
//   tx_data_i       word to transmit
//   tx_valid_i      tx_data_i valid, taken when tx_valid_i & tx_ready_o
//   tx_ready_o      TX FIFO not full
//   tx_busy_o       shifter active or FIFO non-empty
//   tx_o            serial output, idles high
//   rx_i            serial input, asynchronous
//   rx_data_o       last received word, held until the next frame completes
//   rx_valid_o      one-cycle pulse when rx_data_o and error flags update
//   rx_parity_err_o parity mismatch on the flagged frame
//   rx_frame_err_o  stop bit sampled low on the flagged frame
module uart_xcvr_param #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_busy_o,
    output logic                 tx_o,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 rx_parity_err_o,
    output logic                 rx_frame_err_o
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS) + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
    localparam bit                PAR_EN    = (PARITY != 0);
    localparam bit                PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [FCNT_W-1:0]    fifo_cnt_q;
    logic [FCNT_W-1:0]    fifo_cnt_d;
    logic                 fifo_empty_c;
    logic                 wr_en_c;
    logic                 tx_pop_c;
    logic [DATA_BITS-1:0] fifo_head_c;

    logic tx_ready_q;
    logic tx_busy_q;

    assign wr_en_c      = tx_valid_i & tx_ready_q;
    assign fifo_empty_c = (fifo_cnt_q == '0);
    assign fifo_head_c  = fifo_mem_q[rd_ptr_q];

    // Occupancy after this cycle's write and pop.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        unique case ({wr_en_c, tx_pop_c})
            2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            fifo_mem_q[wr_ptr_q] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (tx_pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    state_e               tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q;
    logic                 tx_c;
    logic                 tx_cnt_last_c;

    assign tx_cnt_last_c = (tx_cnt_q == CNT_LAST);

    // State register plus TX datapath and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_c;
            tx_ready_q <= (fifo_cnt_d != FIFO_FULL);
            tx_busy_q  <= (tx_state_d != S_IDLE) || (fifo_cnt_d != '0);
        end
    end

    // Next state; a pop loads the shifter and pre-computes the parity bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop_c   = 1'b0;
        if (tx_state_q != S_IDLE) begin
            tx_cnt_d = tx_cnt_last_c ? '0 : tx_cnt_q + CNT_W'(1);
        end
        unique case (tx_state_q)
            S_IDLE: begin
                if (!fifo_empty_c) begin
                    tx_pop_c   = 1'b1;
                    tx_shift_d = fifo_head_c;
                    tx_par_d   = (^fifo_head_c) ^ PAR_ODD;
                    tx_cnt_d   = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_last_c) begin
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_cnt_last_c) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tx_cnt_last_c) begin
                    tx_bit_d   = '0;
                    tx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_cnt_last_c) begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_bit_d = '0;
                        // Back-to-back frames: next start bit with no idle gap.
                        if (!fifo_empty_c) begin
                            tx_pop_c   = 1'b1;
                            tx_shift_d = fifo_head_c;
                            tx_par_d   = (^fifo_head_c) ^ PAR_ODD;
                            tx_state_d = S_START;
                        end else begin
                            tx_state_d = S_IDLE;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // Line level for the current state; registered into tx_q one cycle later.
    always_comb begin
        tx_c = 1'b1;
        unique case (tx_state_q)
            S_START:  tx_c = 1'b0;
            S_DATA:   tx_c = tx_shift_q[0];
            S_PARITY: tx_c = tx_par_q;
            default:  tx_c = 1'b1;
        endcase
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = tx_ready_q;
    assign tx_busy_o  = tx_busy_q;

    // ------------------------------------------------------------------
    // RX synchroniser and FSM
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;

    state_e               rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_cnt_last_c;
    logic                 rx_done_c;
    logic                 rx_perr_c;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_perr_q;
    logic                 rx_ferr_q;

    assign rx_cnt_last_c = (rx_cnt_q == CNT_LAST);

    // State register, synchroniser and registered RX outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_valid_q <= rx_done_c;
            if (rx_done_c) begin
                rx_data_q <= rx_shift_q;
                rx_perr_q <= rx_perr_c;
                rx_ferr_q <= ~rx_s_q;
            end
        end
    end

    // Next state; a held-low line after a frame never looks like a new edge.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        if (rx_state_q != S_IDLE) begin
            rx_cnt_d = rx_cnt_last_c ? '0 : rx_cnt_q + CNT_W'(1);
        end
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                // Mid start bit: a high line means the edge was a glitch.
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt_last_c) begin
                    rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (rx_cnt_last_c) begin
                    rx_par_d   = rx_s_q;
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_cnt_last_c) begin
                    rx_state_d = S_IDLE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Frame completion strobe and parity check at the stop-bit mid-sample.
    always_comb begin
        rx_done_c = (rx_state_q == S_STOP) && rx_cnt_last_c;
        rx_perr_c = PAR_EN && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD));
    end

    assign rx_data_o       = rx_data_q;
    assign rx_valid_o      = rx_valid_q;
    assign rx_parity_err_o = rx_perr_q;
    assign rx_frame_err_o  = rx_ferr_q;

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Bench for uart_xcvr_param: three instances (8N1, 7E1, 9N2) at 16 clk/bit,
// TX waveform checked cycle by cycle, RX results checked through per-instance
// scoreboard queues filled when stimulus is driven.
module tb_uart_xcvr_param;

    localparam int unsigned CPB = 16;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 8N1, FIFO depth 4
    logic [7:0] d8, rxd8;
    logic v8, rdy8, bsy8, tx8, rx8, sel8, drv8, rv8, pe8, fe8;
    // 7 data bits, even parity
    logic [6:0] d7, rxd7;
    logic v7, rdy7, bsy7, tx7, rx7, sel7, drv7, rv7, pe7, fe7;
    // 9 data bits, 2 stop bits
    logic [8:0] d9, rxd9;
    logic v9, rdy9, bsy9, tx9, rx9, sel9, drv9, rv9, pe9, fe9;

    assign rx8 = sel8 ? tx8 : drv8;
    assign rx7 = sel7 ? tx7 : drv7;
    assign rx9 = sel9 ? tx9 : drv9;

    uart_xcvr_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u8 (
        .clk_i(clk), .rst_i(rst), .tx_data_i(d8), .tx_valid_i(v8), .tx_ready_o(rdy8),
        .tx_busy_o(bsy8), .tx_o(tx8), .rx_i(rx8), .rx_data_o(rxd8), .rx_valid_o(rv8),
        .rx_parity_err_o(pe8), .rx_frame_err_o(fe8));

    uart_xcvr_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u7 (
        .clk_i(clk), .rst_i(rst), .tx_data_i(d7), .tx_valid_i(v7), .tx_ready_o(rdy7),
        .tx_busy_o(bsy7), .tx_o(tx7), .rx_i(rx7), .rx_data_o(rxd7), .rx_valid_o(rv7),
        .rx_parity_err_o(pe7), .rx_frame_err_o(fe7));

    uart_xcvr_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(2)) u9 (
        .clk_i(clk), .rst_i(rst), .tx_data_i(d9), .tx_valid_i(v9), .tx_ready_o(rdy9),
        .tx_busy_o(bsy9), .tx_o(tx9), .rx_i(rx9), .rx_data_o(rxd9), .rx_valid_o(rv9),
        .rx_parity_err_o(pe9), .rx_frame_err_o(fe9));

    int   tests = 0;
    int   fails = 0;
    int   nval8 = 0, nval7 = 0, nval9 = 0;
    exp_t q8[$], q7[$], q9[$];

    // Expected serial level at position pos (clk cycles) into a frame.
    function automatic logic exp_level(input logic [8:0] w, input int db, input bit par_en, input int pos);
        int   sym;
        logic p;
        sym = pos / CPB;
        p = 1'b0;
        for (int i = 0; i < db; i++) p ^= w[i];
        if (sym == 0) return 1'b0;
        if (sym <= db) return w[sym-1];
        if (par_en && sym == db + 1) return p;
        return 1'b1;
    endfunction

    // Scoreboard monitors: every rx_valid pulse must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rv8 === 1'b1) begin
            nval8++;
            tests++;
            if (q8.size() == 0) begin
                fails++;
                $display("FAIL rx8_unexpected: got data=%h perr=%b ferr=%b, expected no rx_valid", rxd8, pe8, fe8);
            end else begin
                e = q8.pop_front();
                if ({1'b0, rxd8, pe8, fe8} !== {e.data, e.perr, e.ferr}) begin
                    fails++;
                    $display("FAIL rx8_word: got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                             rxd8, pe8, fe8, e.data, e.perr, e.ferr);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rv7 === 1'b1) begin
            nval7++;
            tests++;
            if (q7.size() == 0) begin
                fails++;
                $display("FAIL rx7_unexpected: got data=%h perr=%b ferr=%b, expected no rx_valid", rxd7, pe7, fe7);
            end else begin
                e = q7.pop_front();
                if ({2'b0, rxd7, pe7, fe7} !== {e.data, e.perr, e.ferr}) begin
                    fails++;
                    $display("FAIL rx7_word: got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                             rxd7, pe7, fe7, e.data, e.perr, e.ferr);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rv9 === 1'b1) begin
            nval9++;
            tests++;
            if (q9.size() == 0) begin
                fails++;
                $display("FAIL rx9_unexpected: got data=%h perr=%b ferr=%b, expected no rx_valid", rxd9, pe9, fe9);
            end else begin
                e = q9.pop_front();
                if ({rxd9, pe9, fe9} !== {e.data, e.perr, e.ferr}) begin
                    fails++;
                    $display("FAIL rx9_word: got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                             rxd9, pe9, fe9, e.data, e.perr, e.ferr);
                end
            end
        end
    end

    task automatic set_line(input int which, input logic val);
        case (which)
            0:       drv8 = val;
            1:       drv7 = val;
            default: drv9 = val;
        endcase
    endtask

    // Bit-bang one frame onto a bench-driven rx line; leaves the line at stop_v.
    task automatic drive_frame(input int which, input logic [8:0] w, input int db,
                               input bit par_en, input bit par_flip, input logic stop_v);
        logic p;
        p = par_flip;
        for (int i = 0; i < db; i++) p ^= w[i];
        set_line(which, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < db; i++) begin
            set_line(which, w[i]);
            repeat (CPB) @(negedge clk);
        end
        if (par_en) begin
            set_line(which, p);
            repeat (CPB) @(negedge clk);
        end
        set_line(which, stop_v);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({tx8, rdy8, bsy8, rv8, pe8, fe8, rxd8} !== {6'b110000, 8'h00}) begin
            fails++;
            $display("FAIL reset_u8: got tx/rdy/bsy/rv/pe/fe=%b%b%b%b%b%b rx_data=%h, expected 110000 00",
                     tx8, rdy8, bsy8, rv8, pe8, fe8, rxd8);
        end
        tests++;
        if ({tx7, rdy7, bsy7, rv7, pe7, fe7, rxd7} !== {6'b110000, 7'h00}) begin
            fails++;
            $display("FAIL reset_u7: got tx/rdy/bsy/rv/pe/fe=%b%b%b%b%b%b rx_data=%h, expected 110000 00",
                     tx7, rdy7, bsy7, rv7, pe7, fe7, rxd7);
        end
        tests++;
        if ({tx9, rdy9, bsy9, rv9, pe9, fe9, rxd9} !== {6'b110000, 9'h000}) begin
            fails++;
            $display("FAIL reset_u9: got tx/rdy/bsy/rv/pe/fe=%b%b%b%b%b%b rx_data=%h, expected 110000 000",
                     tx9, rdy9, bsy9, rv9, pe9, fe9, rxd9);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_8n1();
        logic lvl;
        @(negedge clk);
        d8 = 8'hA5;
        v8 = 1'b1;
        q8.push_back(exp_t'{9'h0A5, 1'b0, 1'b0});
        for (int n = 0; n < 2 + 160; n++) begin
            @(negedge clk);
            v8 = 1'b0;
            lvl = (n < 2) ? 1'b1 : exp_level(9'h0A5, 8, 1'b0, n - 2);
            tests++;
            if (tx8 !== lvl) begin
                fails++;
                $display("FAIL 8n1_tx cycle %0d: got tx=%b, expected %b", n, tx8, lvl);
            end
        end
        for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge clk);
        tests++;
        if (q8.size() != 0) begin
            fails++;
            $display("FAIL 8n1_rx: got %0d words pending, expected 0", q8.size());
        end
        tests++;
        if ({bsy8, rdy8} !== 2'b01) begin
            fails++;
            $display("FAIL 8n1_idle: got busy=%b ready=%b, expected busy=0 ready=1", bsy8, rdy8);
        end
    endtask

    task automatic test_fifo();
        logic       lvl;
        logic [8:0] w;
        int         k;
        for (int n = 0; n < 3 + 800 + 3; n++) begin
            @(negedge clk);
            if (n < 6) begin
                tests++;
                if (rdy8 !== (n < 5)) begin
                    fails++;
                    $display("FAIL fifo_ready write %0d: got %b, expected %b", n, rdy8, (n < 5));
                end
                d8 = 8'(n + 1);
                v8 = 1'b1;
                if (n < 5) q8.push_back(exp_t'{9'(n + 1), 1'b0, 1'b0});
            end else begin
                v8 = 1'b0;
            end
            k = n - 3;
            if (n < 3 || k >= 800) begin
                lvl = 1'b1;
            end else begin
                w = 9'(k / 160 + 1);
                lvl = exp_level(w, 8, 1'b0, k % 160);
            end
            tests++;
            if (tx8 !== lvl) begin
                fails++;
                $display("FAIL fifo_tx cycle %0d: got tx=%b, expected %b", n, tx8, lvl);
            end
            if (n == 400) begin
                tests++;
                if (bsy8 !== 1'b1) begin
                    fails++;
                    $display("FAIL fifo_busy_mid: got %b, expected 1", bsy8);
                end
            end
        end
        tests++;
        if ({bsy8, rdy8} !== 2'b01) begin
            fails++;
            $display("FAIL fifo_idle: got busy=%b ready=%b, expected busy=0 ready=1", bsy8, rdy8);
        end
        for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge clk);
        tests++;
        if (q8.size() != 0) begin
            fails++;
            $display("FAIL fifo_rx: got %0d words pending, expected 0", q8.size());
        end
    endtask

    task automatic test_parity();
        logic       lvl;
        logic [8:0] words [3];
        bit         flips [3];
        words = '{9'h003, 9'h007, 9'h055};
        flips = '{1'b1, 1'b0, 1'b1};
        @(negedge clk);
        d7 = 7'h03;
        v7 = 1'b1;
        q7.push_back(exp_t'{9'h003, 1'b0, 1'b0});
        for (int n = 0; n < 2 + 160; n++) begin
            @(negedge clk);
            v7 = 1'b0;
            lvl = (n < 2) ? 1'b1 : exp_level(9'h003, 7, 1'b1, n - 2);
            tests++;
            if (tx7 !== lvl) begin
                fails++;
                $display("FAIL parity_tx cycle %0d: got tx=%b, expected %b", n, tx7, lvl);
            end
        end
        for (int i = 0; i < 100 && q7.size() != 0; i++) @(negedge clk);
        drv7 = 1'b1;
        sel7 = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            q7.push_back(exp_t'{words[i], flips[i], 1'b0});
            drive_frame(1, words[i], 7, 1'b1, flips[i], 1'b1);
        end
        for (int i = 0; i < 100 && q7.size() != 0; i++) @(negedge clk);
        tests++;
        if (q7.size() != 0) begin
            fails++;
            $display("FAIL parity_rx: got %0d words pending, expected 0", q7.size());
        end
        sel7 = 1'b1;
    endtask

    task automatic test_glitch_frame();
        int base;
        drv8 = 1'b1;
        sel8 = 1'b0;
        repeat (4) @(negedge clk);
        base = nval8;
        drv8 = 1'b0;
        repeat (4) @(negedge clk);
        drv8 = 1'b1;
        repeat (60) @(negedge clk);
        tests++;
        if (nval8 - base != 0) begin
            fails++;
            $display("FAIL glitch: got %0d rx_valid pulses, expected 0", nval8 - base);
        end
        q8.push_back(exp_t'{9'h096, 1'b0, 1'b1});
        drive_frame(0, 9'h096, 8, 1'b0, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        tests++;
        if (nval8 - base != 1) begin
            fails++;
            $display("FAIL frame_err_break: got %0d rx_valid pulses, expected 1", nval8 - base);
        end
        drv8 = 1'b1;
        repeat (20) @(negedge clk);
        q8.push_back(exp_t'{9'h05A, 1'b0, 1'b0});
        drive_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge clk);
        tests++;
        if (q8.size() != 0 || nval8 - base != 2) begin
            fails++;
            $display("FAIL after_break: got %0d pending, %0d pulses, expected 0 pending, 2 pulses",
                     q8.size(), nval8 - base);
        end
        sel8 = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int base;
        int lows;
        @(negedge clk);
        d8 = 8'h77;
        v8 = 1'b1;
        @(negedge clk);
        d8 = 8'h11;
        @(negedge clk);
        v8 = 1'b0;
        repeat (80) @(negedge clk);
        base = nval8;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({tx8, rdy8, bsy8, rv8} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_mid: got tx=%b ready=%b busy=%b rv=%b, expected 1 1 0 0", tx8, rdy8, bsy8, rv8);
        end
        lows = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (tx8 !== 1'b1) lows++;
        end
        tests++;
        if (lows != 0) begin
            fails++;
            $display("FAIL reset_discard: got %0d tx-low cycles after reset, expected 0", lows);
        end
        tests++;
        if (nval8 - base != 0) begin
            fails++;
            $display("FAIL reset_rx_abort: got %0d rx_valid pulses, expected 0", nval8 - base);
        end
        d8 = 8'h3C;
        v8 = 1'b1;
        q8.push_back(exp_t'{9'h03C, 1'b0, 1'b0});
        @(negedge clk);
        v8 = 1'b0;
        for (int i = 0; i < 300 && q8.size() != 0; i++) @(negedge clk);
        tests++;
        if (q8.size() != 0) begin
            fails++;
            $display("FAIL reset_clean_frame: got %0d words pending, expected 0", q8.size());
        end
    endtask

    task automatic test_stop2();
        logic       lvl;
        logic [8:0] w;
        int         k;
        @(negedge clk);
        d9 = 9'h1FF;
        v9 = 1'b1;
        q9.push_back(exp_t'{9'h1FF, 1'b0, 1'b0});
        q9.push_back(exp_t'{9'h000, 1'b0, 1'b0});
        for (int n = 0; n < 2 + 384 + 4; n++) begin
            @(negedge clk);
            if (n == 0) d9 = 9'h000;
            else v9 = 1'b0;
            k = n - 2;
            if (n < 2 || k >= 384) begin
                lvl = 1'b1;
            end else begin
                w = (k < 192) ? 9'h1FF : 9'h000;
                lvl = exp_level(w, 9, 1'b0, k % 192);
            end
            tests++;
            if (tx9 !== lvl) begin
                fails++;
                $display("FAIL stop2_tx cycle %0d: got tx=%b, expected %b", n, tx9, lvl);
            end
        end
        tests++;
        if (bsy9 !== 1'b0) begin
            fails++;
            $display("FAIL stop2_busy: got %b, expected 0", bsy9);
        end
        for (int i = 0; i < 100 && q9.size() != 0; i++) @(negedge clk);
        tests++;
        if (q9.size() != 0) begin
            fails++;
            $display("FAIL stop2_rx: got %0d words pending, expected 0", q9.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        d8 = '0; d7 = '0; d9 = '0;
        v8 = 1'b0; v7 = 1'b0; v9 = 1'b0;
        sel8 = 1'b1; sel7 = 1'b1; sel9 = 1'b1;
        drv8 = 1'b1; drv7 = 1'b1; drv9 = 1'b1;
        test_reset();
        test_8n1();
        test_fifo();
        test_parity();
        test_glitch_frame();
        test_reset_midframe();
        test_stop2();
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
